mutative_reconfig_ctrl: RTL and testbench
=========================================

Name: mutative_reconfig_ctrl

Overview:
- Sequences associativity changes of the mutative cache.
- Accepts upscale/downscale requests from the associativity predictor over the setup_valid/setup_ready handshake.
- Stalls the CPU side, waits for the cache to go quiescent, then walks every line: writes back dirty lines and invalidates all lines.
- Commits the new 2-bit setup, then enforces a cooldown before accepting the next request.

Parameters:
SET_SIZE, 16, sets per way in base geometry (power of 2)
WAYS, 4, physical ways (power of 2)
COOLDOWN, 64, cycles after a commit during which no request is accepted (>=1)
RESET_SETUP, 0, setup value after reset (0..3)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
setup_valid  in  1  predictor request pending
setup_update  in  1  request direction: 0 = upscale (setup+1), 1 = downscale (setup-1)
setup_ready  out  1  one-cycle acknowledge of the request
setup  out  2  current committed configuration, fed to cache and predictor
cache_idle  in  1  no miss or writeback outstanding in the cache
stall  out  1  block new CPU requests
scan_set  out  $clog2(SET_SIZE)  set index under scan
scan_way  out  $clog2(WAYS)  way index under scan
line_valid  in  1  metadata valid bit of scan_set/scan_way (combinational lookup)
line_dirty  in  1  metadata dirty bit of the same line
wb_req  out  1  write back line scan_set/scan_way
wb_done  in  1  writeback complete
inval_en  out  1  clear valid and dirty of line scan_set/scan_way this cycle
reconfig_count  out  16  number of committed reconfigurations, saturating

Behaviour:
- Reset (any cycle, including mid-flush): state = S_IDLE, setup = RESET_SETUP, idx = 0, cooldown counter = 0, reconfig_count = 0. stall, wb_req, inval_en and setup_ready are all 0. A partially completed flush is abandoned.
- idx is a counter of width $clog2(SET_SIZE*WAYS). scan_way = idx low bits; scan_set = idx high bits.

States:
- S_IDLE: stall = 0. When setup_valid = 1, dir <= setup_update.
  - Illegal target (setup == 3 and dir = 0, or setup == 0 and dir = 1): setup_ready = 1 in this same cycle. Stay in S_IDLE; no flush, no count change, no cooldown.
  - Otherwise go to S_DRAIN.
- S_DRAIN: stall = 1. When cache_idle = 1, go to S_SCAN with idx = 0.
- S_SCAN: stall = 1.
  - If line_valid and line_dirty: go to S_WB.
  - Otherwise: inval_en = 1 this cycle. If idx is last, go to S_COMMIT; else idx++.
  - Result: one cycle per clean or invalid line.
- S_WB: stall = 1, wb_req = 1. wb_req is held until wb_done is sampled, then go to S_INVAL. wb_done while not in S_WB is ignored.
- S_INVAL: inval_en = 1. If idx is last, go to S_COMMIT; else idx++ and go to S_SCAN.
- S_COMMIT: stall = 1, setup_ready = 1 (single cycle).
  - setup <= setup + 1 (dir = 0) or setup - 1 (dir = 1).
  - reconfig_count++, saturating at 0xFFFF.
  - Load cooldown = COOLDOWN and go to S_COOL.
- S_COOL: stall = 0. Decrement cooldown each cycle; go to S_IDLE when the value reaches 1. setup_valid is ignored (setup_ready stays 0), so the predictor holds its request.

Rules:
- setup_update is sampled only in S_IDLE. Changes to setup_valid or setup_update after acceptance have no effect.
- setup changes only on the clock edge that ends S_COMMIT. The predictor sees the new setup in the cycle after setup_ready.
- wb_req and inval_en are never asserted together. Each line gets exactly one inval_en per flush.
- idx wraps to 0 on commit.

Latency:
- Legal request, cache_idle = 1, all lines clean, SET_SIZE*WAYS = 64.
- Cycle 0: setup_valid sampled in S_IDLE. S_DRAIN in cycle 1; scan occupies cycles 2..65; setup_ready = 1 in cycle 66; new setup visible in cycle 67.

Test Plan:
- Reset, setup_valid = 1, setup_update = 0, cache_idle = 1, all lines clean -> setup_ready pulse at cycle 66, setup 0 -> 1, exactly 64 inval_en pulses, reconfig_count = 1, stall high in cycles 1..66.
- Lines (set 3, way 2) and (set 15, way 3) dirty, wb_done returned 5 cycles after each wb_req rises -> wb_req held 5 cycles each, scan_set/scan_way = 3/2 then 15/3, 64 inval_en pulses total, setup_ready at cycle 78.
- setup = 0 with setup_update = 1, then setup = 3 via three upscales with setup_update = 0 -> immediate setup_ready in the acceptance cycle, setup unchanged, no stall, reconfig_count unchanged.
- cache_idle held 0 for 10 cycles after acceptance -> stall high throughout, no scan_set/scan_way activity or inval_en until cache_idle = 1.
- setup_valid held high after a commit with COOLDOWN = 64 -> no setup_ready for 64 cycles, then the next request is accepted; setup steps 1 -> 2.
- Assert rst while in S_WB -> next cycle wb_req = 0, stall = 0, setup = RESET_SETUP, a subsequent request performs a full 64-line scan from idx 0.

Source files
------------

// File: rtl/mutative_reconfig_ctrl.sv
// Associativity reconfiguration sequencer for the mutative cache:
// drain, flush every line, commit the new setup, then cool down.
module mutative_reconfig_ctrl #(
   parameter int         SET_SIZE    = 16,
   parameter int         WAYS        = 4,
   parameter int         COOLDOWN    = 64,
   parameter logic [1:0] RESET_SETUP = 2'd0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        setup_valid,
   input  logic                        setup_update,
   output logic                        setup_ready,
   output logic [1:0]                  setup,
   input  logic                        cache_idle,
   output logic                        stall,
   output logic [$clog2(SET_SIZE)-1:0] scan_set,
   output logic [$clog2(WAYS)-1:0]     scan_way,
   input  logic                        line_valid,
   input  logic                        line_dirty,
   output logic                        wb_req,
   input  logic                        wb_done,
   output logic                        inval_en,
   output logic [15:0]                 reconfig_count
);

   localparam int SW = $clog2(SET_SIZE);
   localparam int WW = $clog2(WAYS);
   localparam int IW = SW + WW;
   localparam int CW = $clog2(COOLDOWN + 1);
   localparam logic [IW-1:0] LAST = IW'(SET_SIZE * WAYS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_SCAN,
      S_WB,
      S_INVAL,
      S_COMMIT,
      S_COOL
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_dir;
   logic [1:0]    r_setup;
   logic [IW-1:0] r_idx;
   logic [CW-1:0] r_cool;
   logic [15:0]   r_count;

   logic          w_illegal;
   logic          w_last;
   logic          w_dirty_hit;
   logic          w_idx_inc;

   assign w_illegal   = ((r_setup == 2'd3) && !setup_update) ||
                        ((r_setup == 2'd0) && setup_update);
   assign w_last      = (r_idx == LAST);
   assign w_dirty_hit = line_valid & line_dirty;

   assign setup          = r_setup;
   assign reconfig_count = r_count;
   assign scan_way       = r_idx[WW-1:0];
   assign scan_set       = r_idx[IW-1:WW];

   always_comb begin
      w_next      = r_state;
      stall       = 1'b0;
      wb_req      = 1'b0;
      inval_en    = 1'b0;
      setup_ready = 1'b0;
      w_idx_inc   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (setup_valid) begin
               if (w_illegal) setup_ready = 1'b1;
               else           w_next      = S_DRAIN;
            end
         end
         S_DRAIN: begin
            stall = 1'b1;
            if (cache_idle) w_next = S_SCAN;
         end
         S_SCAN: begin
            stall = 1'b1;
            if (w_dirty_hit) begin
               w_next = S_WB;
            end else begin
               inval_en = 1'b1;
               if (w_last) w_next    = S_COMMIT;
               else        w_idx_inc = 1'b1;
            end
         end
         S_WB: begin
            stall  = 1'b1;
            wb_req = 1'b1;
            if (wb_done) w_next = S_INVAL;
         end
         S_INVAL: begin
            stall    = 1'b1;
            inval_en = 1'b1;
            if (w_last) begin
               w_next = S_COMMIT;
            end else begin
               w_idx_inc = 1'b1;
               w_next    = S_SCAN;
            end
         end
         S_COMMIT: begin
            stall       = 1'b1;
            setup_ready = 1'b1;
            w_next      = S_COOL;
         end
         S_COOL: begin
            if (r_cool <= CW'(1)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_dir   <= 1'b0;
         r_setup <= RESET_SETUP;
         r_idx   <= '0;
         r_cool  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && setup_valid) r_dir <= setup_update;
         if (r_state == S_DRAIN && cache_idle) begin
            r_idx <= '0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + IW'(1);
         end else if (r_state == S_COMMIT) begin
            r_idx <= '0;
         end
         if (r_state == S_COMMIT) begin
            r_setup <= r_dir ? r_setup - 2'd1 : r_setup + 2'd1;
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            r_cool  <= CW'(COOLDOWN);
         end else if (r_state == S_COOL && r_cool != '0) begin
            r_cool <= r_cool - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mutative_reconfig_ctrl.sv
// Directed bench for mutative_reconfig_ctrl with a line-metadata model,
// a writeback responder and a scoreboard of expected commits.
module tb_mutative_reconfig_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       setup_valid;
   logic       setup_update;
   logic       setup_ready;
   logic [1:0] setup;
   logic       cache_idle;
   logic       stall;
   logic [3:0] scan_set;
   logic [1:0] scan_way;
   logic       line_valid;
   logic       line_dirty;
   logic       wb_req;
   logic       wb_done;
   logic       inval_en;
   logic [15:0] reconfig_count;

   always #5 clk = ~clk;

   mutative_reconfig_ctrl #(
      .SET_SIZE(16), .WAYS(4), .COOLDOWN(64), .RESET_SETUP(2'd0)
   ) dut (
      .clk(clk), .rst(rst),
      .setup_valid(setup_valid), .setup_update(setup_update),
      .setup_ready(setup_ready), .setup(setup),
      .cache_idle(cache_idle), .stall(stall),
      .scan_set(scan_set), .scan_way(scan_way),
      .line_valid(line_valid), .line_dirty(line_dirty),
      .wb_req(wb_req), .wb_done(wb_done),
      .inval_en(inval_en), .reconfig_count(reconfig_count)
   );

   logic [63:0] mem_v, mem_d, pre_v, pre_d;
   logic        pre_req;
   logic [5:0]  line_idx;
   int          wb_cnt = 0;

   assign line_idx   = {scan_set, scan_way};
   assign line_valid = mem_v[line_idx];
   assign line_dirty = mem_d[line_idx];

   always @(posedge clk) begin
      if (pre_req) begin
         mem_v <= pre_v;
         mem_d <= pre_d;
      end else if (inval_en) begin
         mem_v[line_idx] <= 1'b0;
         mem_d[line_idx] <= 1'b0;
      end
   end

   // wb_done arrives during the fifth cycle of a wb_req assertion
   always @(negedge clk) begin
      if (wb_req) begin
         wb_cnt  = wb_cnt + 1;
         wb_done = (wb_cnt == 5);
      end else begin
         wb_cnt  = 0;
         wb_done = 1'b0;
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int rdy;
      int setup;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   wb_pos[$];

   task automatic check(input string tag, input int obs, input int want);
      n_chk++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic preset(input logic [63:0] v, input logic [63:0] d);
      @(negedge clk);
      pre_v   = v;
      pre_d   = d;
      pre_req = 1'b1;
      @(negedge clk);
      pre_req = 1'b0;
   endtask

   task automatic run_req(input string tag, input logic dir, input int acc,
                          input int drain, input int ndirty, input bit legal,
                          input bit hold, input int exp_setup,
                          input int exp_cnt);
      exp_t e;
      int   k, rdy_seen, stalls, invs, first_inv, wbc, ovl;
      logic prev_wb;
      e.rdy   = legal ? acc + 66 + drain + 6 * ndirty : acc;
      e.setup = exp_setup;
      e.cnt   = exp_cnt;
      sb.push_back(e);
      wb_pos.delete();
      k = 0; rdy_seen = -1; stalls = 0; invs = 0;
      first_inv = -1; wbc = 0; ovl = 0; prev_wb = 1'b0;
      @(negedge clk);
      setup_valid  = 1'b1;
      setup_update = dir;
      if (drain > 0) cache_idle = 1'b0;
      while (rdy_seen < 0 && k < 400) begin
         #1;
         if (stall) stalls++;
         if (inval_en) begin
            invs++;
            if (first_inv < 0) first_inv = k;
         end
         if (wb_req) wbc++;
         if (wb_req && !prev_wb) wb_pos.push_back(int'(line_idx));
         prev_wb = wb_req;
         if (wb_req && inval_en) ovl++;
         if (setup_ready) rdy_seen = k;
         @(negedge clk);
         k++;
         if (k == acc + 1 && !hold) begin
            setup_valid  = 1'b0;
            setup_update = ~dir;
         end
         if (drain > 0 && k == acc + drain + 1) cache_idle = 1'b1;
      end
      setup_valid = 1'b0;
      cache_idle  = 1'b1;
      #1;
      if (sb.size() == 0) begin
         check({tag, " scoreboard"}, 0, 1);
      end else begin
         e = sb.pop_front();
         check({tag, " ready cycle"}, rdy_seen, e.rdy);
         check({tag, " setup"}, int'(setup), e.setup);
         check({tag, " count"}, int'(reconfig_count), e.cnt);
         check({tag, " stall cycles"}, stalls, legal ? e.rdy - acc : 0);
      end
      check({tag, " ready pulse"}, int'(setup_ready), 0);
      check({tag, " inval pulses"}, invs, legal ? 64 : 0);
      check({tag, " first inval"}, first_inv, legal ? acc + 2 + drain : -1);
      check({tag, " wb cycles"}, wbc, 5 * ndirty);
      check({tag, " wb/inval overlap"}, ovl, 0);
   endtask

   initial begin
      int k;
      logic [63:0] d;
      rst          = 1'b1;
      setup_valid  = 1'b0;
      setup_update = 1'b0;
      cache_idle   = 1'b1;
      pre_v        = '1;
      pre_d        = '0;
      pre_req      = 1'b1;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      pre_req = 1'b0;
      #1;
      check("reset setup", int'(setup), 0);
      check("reset stall", int'(stall), 0);
      check("reset wb_req", int'(wb_req), 0);
      check("reset inval", int'(inval_en), 0);
      check("reset ready", int'(setup_ready), 0);
      check("reset count", int'(reconfig_count), 0);
      check("reset idx", int'(line_idx), 0);

      run_req("up clean", 1'b0, 0, 0, 0, 1'b1, 1'b0, 1, 1);
      run_req("cooldown", 1'b0, 63, 0, 0, 1'b1, 1'b1, 2, 2);

      d = '0;
      d[14] = 1'b1;
      d[63] = 1'b1;
      preset(d, d);
      idle(64);
      run_req("dirty", 1'b0, 0, 0, 2, 1'b1, 1'b0, 3, 3);
      check("dirty wb count", wb_pos.size(), 2);
      if (wb_pos.size() == 2) begin
         check("dirty wb line0", wb_pos[0], 14);
         check("dirty wb line1", wb_pos[1], 63);
      end
      idle(64);

      run_req("up at 3", 1'b0, 0, 0, 0, 1'b0, 1'b0, 3, 3);
      run_req("drain", 1'b1, 0, 10, 0, 1'b1, 1'b0, 2, 4);
      idle(64);

      d = '0;
      d[5] = 1'b1;
      preset('1, d);
      idle(2);
      @(negedge clk);
      setup_valid  = 1'b1;
      setup_update = 1'b1;
      @(negedge clk);
      setup_valid = 1'b0;
      k = 0;
      while (!wb_req && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("rst wb reached", int'(wb_req), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst wb_req", int'(wb_req), 0);
      check("rst stall", int'(stall), 0);
      check("rst setup", int'(setup), 0);
      check("rst count", int'(reconfig_count), 0);
      rst = 1'b0;

      run_req("down at 0", 1'b1, 0, 0, 0, 1'b0, 1'b0, 0, 0);
      run_req("after rst", 1'b0, 0, 0, 1, 1'b1, 1'b0, 1, 1);
      check("after rst wb line", wb_pos.size() > 0 ? wb_pos[0] : -1, 5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
